// File: rtl/hpu_axil_pkg.sv
// ============================================================================
// Module      : hpu_axil_pkg
// Description : Shared FSM states, opcodes, response codes and register offsets
//               for the accelerator's AXI4-Lite register initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpu_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_WR_B     = 3'd2,
    ST_RD_AR    = 3'd3,
    ST_RD_R     = 3'd4,
    ST_POLL_GAP = 3'd5,
    ST_RSP      = 3'd6
  } state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [31:0] REG_RUNGEN  = 32'h0000_0000;
  localparam logic [31:0] REG_CONTROL = 32'h0000_0010;

  function automatic logic poll_match(input logic [31:0] data,
                                      input logic [31:0] mask,
                                      input logic [31:0] value);
    return (data & mask) == value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_poll_timer.sv
// ============================================================================
// Module      : axil_poll_timer
// Description : Inter-poll gap down-counter and saturating poll-read counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_poll_timer #(
  parameter int POLL_GAP  = 8,
  parameter int MAX_POLLS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_read_done,
  input  logic i_gap_en,
  output logic o_gap_done,
  output logic o_last_poll
);

  // Gap loads N-1 so the owner spends exactly N cycles waiting before it leaves.
  localparam logic [15:0] C_GAP_LOAD = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
  localparam logic [15:0] C_MAX      = 16'(MAX_POLLS);
  localparam logic [15:0] C_LAST     = (MAX_POLLS > 0) ? 16'(MAX_POLLS - 1) : 16'd0;

  logic [15:0] r_gap;
  logic [15:0] r_poll_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap      <= 16'd0;
      r_poll_cnt <= 16'd0;
    end else begin
      if (i_clear) begin
        r_poll_cnt <= 16'd0;
      end else if (i_read_done && (r_poll_cnt != C_MAX)) begin
        r_poll_cnt <= r_poll_cnt + 16'd1;
      end

      if (i_read_done) begin
        r_gap <= C_GAP_LOAD;
      end else if (i_gap_en && (r_gap != 16'd0)) begin
        r_gap <= r_gap - 16'd1;
      end
    end
  end

  assign o_gap_done  = (r_gap == 16'd0);
  // True while the read now completing is the MAX_POLLS-th one.
  assign o_last_poll = (r_poll_cnt >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/axil_reg_master.sv
// ============================================================================
// Module      : axil_reg_master
// Description : One-command-at-a-time AXI4-Lite initiator: write, read and poll.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_master
  import hpu_axil_pkg::*;
#(
  parameter int POLL_GAP  = 8,
  parameter int MAX_POLLS = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_mask;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_cmd_ready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic        r_rsp_timeout;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_poll_rd;
  logic w_hit;
  logic w_gap_done;
  logic w_last_poll;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_aw_hs   = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid  && M_AXI_WREADY;
  assign w_b_hs    = r_bready  && M_AXI_BVALID;
  assign w_ar_hs   = r_arvalid && M_AXI_ARREADY;
  assign w_r_hs    = r_rready  && M_AXI_RVALID;
  assign w_poll_rd = w_r_hs && (r_op == OP_POLL);
  assign w_hit     = poll_match(M_AXI_RDATA, r_mask, r_wdata);

  axil_poll_timer #(
    .POLL_GAP  (POLL_GAP),
    .MAX_POLLS (MAX_POLLS)
  ) u_poll_timer (
    .clk         (M_AXI_ACLK),
    .rst_n       (M_AXI_ARESETN),
    .i_clear     (w_accept),
    .i_read_done (w_poll_rd),
    .i_gap_en    (r_state == ST_POLL_GAP),
    .o_gap_done  (w_gap_done),
    .o_last_poll (w_last_poll)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_WR;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_wstrb       <= 4'd0;
      r_mask        <= 32'd0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_mask      <= cmd_mask;
            r_cmd_ready <= 1'b0;
            if (cmd_op == OP_WR) begin
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_AR;
            end
          end
        end

        ST_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_rdata <= 32'd0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end

        ST_RD_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            // A match or a bus error ends the poll even on the final permitted read.
            if ((r_op != OP_POLL) || w_hit || (M_AXI_RRESP != OKAY)) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RSP;
            end else if (w_last_poll) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_state       <= ST_RSP;
            end else if (POLL_GAP == 0) begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_AR;
            end else begin
              r_state <= ST_POLL_GAP;
            end
          end
        end

        ST_POLL_GAP: begin
          if (w_gap_done) begin
            r_arvalid <= 1'b1;
            r_state   <= ST_RD_AR;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire
